// File: rtl/xb_gpio_host.sv
// -----------------------------------------------------------------------------
// xb_gpio_host
//
// Avalon-MM host for the crossbar GPIO register slave. A command/response
// front end lets hardware sequencers perform single writes, single reads and
// masked poll-until-match reads. Each poll attempt is one read. After the first
// attempt the host retries at most cmd_timeout more times.
//
// Ports
//   clk, reset_n     rising-edge clock, asynchronous active-low reset
//   cmd_valid/ready  command handshake; cmd_ready is high only while idle
//   cmd_op           00 write, 01 read, 10 poll, 11 illegal
//   cmd_addr         target register word address
//   cmd_data         write data (write) or compare value (poll)
//   cmd_mask         poll compare mask
//   cmd_timeout      poll retries after the first attempt
//   rsp_valid        one-cycle response strobe, no backpressure
//   rsp_data         read data, written data, or 0 for an illegal op
//   rsp_status       00 ok, 01 poll timeout, 10 illegal op
//   address, chipselect, write_n, writedata   Avalon host outputs (registered)
//   readdata         Avalon read data, valid one cycle after the address
// -----------------------------------------------------------------------------
module xb_gpio_host #(
   parameter int ADDR_W = 2,
   parameter int DATA_W = 32,
   parameter int TMO_W  = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_data,
   input  logic [DATA_W-1:0] cmd_mask,
   input  logic [TMO_W-1:0]  cmd_timeout,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic [1:0]        rsp_status,
   output logic [ADDR_W-1:0] address,
   output logic              chipselect,
   output logic              write_n,
   output logic [DATA_W-1:0] writedata,
   input  logic [DATA_W-1:0] readdata
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_READ  = 2'b01;
   localparam logic [1:0] OP_POLL  = 2'b10;

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_TIMEOUT = 2'b01;
   localparam logic [1:0] ST_ILLEGAL = 2'b10;

   state_t             state;
   logic [1:0]         op_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [DATA_W-1:0]  data_q;
   logic [DATA_W-1:0]  mask_q;
   logic [TMO_W-1:0]   tmo_q;
   logic [TMO_W-1:0]   attempt;

   // Plain reads always complete on their single attempt. Polls complete only
   // when the masked bits agree.
   logic rd_match;
   assign rd_match = (op_q == OP_READ) || ((readdata & mask_q) == (data_q & mask_q));

   // NOTE: all state and registered outputs use non-blocking assignments, so
   // every register samples the values from before the edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         op_q       <= 2'b00;
         addr_q     <= '0;
         data_q     <= '0;
         mask_q     <= '0;
         tmo_q      <= '0;
         attempt    <= '0;
         cmd_ready  <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_data   <= '0;
         rsp_status <= ST_OK;
         address    <= '0;
         chipselect <= 1'b0;
         write_n    <= 1'b1;
         writedata  <= '0;
      end else begin
         // The response strobe lasts one cycle unless a branch below raises it.
         rsp_valid <= 1'b0;

         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  op_q      <= cmd_op;
                  addr_q    <= cmd_addr;
                  data_q    <= cmd_data;
                  mask_q    <= cmd_mask;
                  tmo_q     <= cmd_timeout;
                  attempt   <= '0;
                  cmd_ready <= 1'b0;
                  case (cmd_op)
                     OP_WRITE: begin
                        state      <= S_WRITE;
                        chipselect <= 1'b1;
                        write_n    <= 1'b0;
                        address    <= cmd_addr;
                        writedata  <= cmd_data;
                     end
                     OP_READ, OP_POLL: begin
                        state      <= S_ISSUE;
                        chipselect <= 1'b1;
                        address    <= cmd_addr;
                     end
                     default: begin
                        // Illegal op: answer at once and issue no bus cycle.
                        state      <= S_RESP;
                        rsp_valid  <= 1'b1;
                        rsp_data   <= '0;
                        rsp_status <= ST_ILLEGAL;
                     end
                  endcase
               end
            end

            S_WRITE: begin
               chipselect <= 1'b0;
               write_n    <= 1'b1;
               rsp_valid  <= 1'b1;
               rsp_data   <= data_q;
               rsp_status <= ST_OK;
               state      <= S_RESP;
            end

            S_ISSUE: begin
               // The slave registers readdata, so the compare waits one cycle.
               chipselect <= 1'b0;
               state      <= S_WAIT;
            end

            S_WAIT: begin
               if (rd_match) begin
                  rsp_valid  <= 1'b1;
                  rsp_data   <= readdata;
                  rsp_status <= ST_OK;
                  state      <= S_RESP;
               end else if (attempt == tmo_q) begin
                  // The equality test ends the poll before attempt can wrap,
                  // even for an all-ones retry count.
                  rsp_valid  <= 1'b1;
                  rsp_data   <= readdata;
                  rsp_status <= ST_TIMEOUT;
                  state      <= S_RESP;
               end else begin
                  attempt    <= attempt + 1'b1;
                  chipselect <= 1'b1;
                  address    <= addr_q;
                  state      <= S_ISSUE;
               end
            end

            S_RESP: begin
               cmd_ready <= 1'b1;
               state     <= S_IDLE;
            end

            default: begin
               state      <= S_IDLE;
               cmd_ready  <= 1'b1;
               chipselect <= 1'b0;
               write_n    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_xb_gpio_host.sv
// -----------------------------------------------------------------------------
// tb_xb_gpio_host
//
// Self-checking bench for xb_gpio_host. It connects the host to a behavioural
// GPIO slave. Address 0 reads in_port and writes out_port. Other addresses
// read as 0. readdata is registered. A reference model predicts the latency,
// data, status and chipselect pulse count of every command. The model works
// from the command rules and from a per-cycle schedule of in_port values.
// The retry width is reduced so that an all-ones retry count stays short.
// -----------------------------------------------------------------------------
module tb_xb_gpio_host;

   localparam int AW = 2;
   localparam int DW = 32;
   localparam int TW = 4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_data;
   logic [DW-1:0] cmd_mask;
   logic [TW-1:0] cmd_timeout;
   logic          rsp_valid;
   logic [DW-1:0] rsp_data;
   logic [1:0]    rsp_status;
   logic [AW-1:0] address;
   logic          chipselect;
   logic          write_n;
   logic [DW-1:0] writedata;
   logic [DW-1:0] readdata;

   logic [DW-1:0] in_port;
   logic [DW-1:0] out_port;
   logic [DW-1:0] sched [0:63];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   xb_gpio_host #(.ADDR_W(AW), .DATA_W(DW), .TMO_W(TW)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_addr    (cmd_addr),
      .cmd_data    (cmd_data),
      .cmd_mask    (cmd_mask),
      .cmd_timeout (cmd_timeout),
      .rsp_valid   (rsp_valid),
      .rsp_data    (rsp_data),
      .rsp_status  (rsp_status),
      .address     (address),
      .chipselect  (chipselect),
      .write_n     (write_n),
      .writedata   (writedata),
      .readdata    (readdata)
   );

   // Behavioural GPIO slave. The read mux is registered on every clock.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata <= '0;
         out_port <= '0;
      end else begin
         if (chipselect && !write_n && address == 2'd0) out_port <= writedata;
         readdata <= (address == 2'd0) ? in_port : '0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   // Reference model. Cycle c counts from the accept cycle (c = 0). The value
   // that attempt k compares is the value driven on in_port during cycle 1+2k.
   task automatic model(input int op, input int addr, input logic [31:0] data,
                        input logic [31:0] mask, input int tmo,
                        output int lat, output logic [31:0] rdat,
                        output int st, output int pulses);
      logic [31:0] v;
      bit          done;
      case (op)
         0: begin lat = 2; rdat = data; st = 0; pulses = 1; end
         1: begin lat = 3; rdat = (addr == 0) ? sched[1] : 32'd0; st = 0; pulses = 1; end
         2: begin
            done = 1'b0;
            lat = 0; rdat = 0; st = 0; pulses = 0;
            for (int k = 0; k <= tmo; k++) begin
               if (!done) begin
                  v = (addr == 0) ? sched[1 + 2 * k] : 32'd0;
                  pulses = k + 1;
                  rdat   = v;
                  lat    = 3 + 2 * k;
                  if ((v & mask) == (data & mask)) done = 1'b1;
               end
            end
            st = done ? 0 : 1;
         end
         default: begin lat = 1; rdat = 0; st = 2; pulses = 0; end
      endcase
   endtask

   // Issue one command at the current falling edge and follow it to its
   // response. Compare the observed behaviour with the model.
   task automatic run_cmd(input string tag, input int op, input int addr,
                          input logic [31:0] data, input logic [31:0] mask, input int tmo);
      int          e_lat, e_st, e_pulses;
      logic [31:0] e_data;
      int          lat, pulses, overlap;
      logic [31:0] got_data;
      int          got_st;
      bit          prev_cs;
      bit          seen;
      model(op, addr, data, mask, tmo, e_lat, e_data, e_st, e_pulses);

      check({tag, " ready"}, cmd_ready, 1);
      cmd_valid   = 1'b1;
      cmd_op      = op[1:0];
      cmd_addr    = addr[AW-1:0];
      cmd_data    = data;
      cmd_mask    = mask;
      cmd_timeout = tmo[TW-1:0];
      in_port     = sched[0];
      @(negedge clk);
      // After acceptance the inputs must be ignored, so scramble them.
      cmd_valid   = 1'b0;
      cmd_op      = 2'($urandom);
      cmd_addr    = AW'($urandom);
      cmd_data    = $urandom;
      cmd_mask    = $urandom;
      cmd_timeout = TW'($urandom);

      lat = -1; pulses = 0; overlap = 0; got_data = 'x; got_st = -1;
      prev_cs = 1'b0; seen = 1'b0;
      for (int c = 1; c <= 60 && !seen; c++) begin
         in_port = sched[c];
         if (c == 1 && op == 0) begin
            check({tag, " wr write_n"}, write_n, 0);
            check({tag, " wr data"}, writedata, data);
            check({tag, " wr addr"}, address, addr);
         end
         if (c == 2 && op == 0) check({tag, " wr strobe one cycle"}, write_n, 1);
         if (c == 1 && (op == 1 || op == 2)) begin
            check({tag, " rd addr"}, address, addr);
            check({tag, " rd write_n"}, write_n, 1);
         end
         if (chipselect) pulses++;
         if (chipselect && prev_cs) overlap++;
         prev_cs = chipselect;
         if (rsp_valid) begin
            lat      = c;
            got_data = rsp_data;
            got_st   = rsp_status;
            seen     = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      check({tag, " latency"}, lat, e_lat);
      check({tag, " rsp_data"}, got_data, e_data);
      check({tag, " rsp_status"}, got_st, e_st);
      check({tag, " cs pulses"}, pulses, e_pulses);
      check({tag, " cs back-to-back"}, overlap, 0);
      @(negedge clk);
      check({tag, " strobe one cycle"}, rsp_valid, 0);
      check({tag, " ready after"}, cmd_ready, 1);
      if (op == 0 && addr == 0) check({tag, " out_port"}, out_port, data);
   endtask

   initial begin
      int          nrsp;
      logic [31:0] d, m;
      reset_n     = 1'b0;
      cmd_valid   = 1'b0;
      cmd_op      = 2'b00;
      cmd_addr    = '0;
      cmd_data    = '0;
      cmd_mask    = '0;
      cmd_timeout = '0;
      in_port     = '0;
      for (int i = 0; i < 64; i++) sched[i] = '0;

      // Reset state.
      repeat (2) @(negedge clk);
      check("rst chipselect", chipselect, 0);
      check("rst write_n", write_n, 1);
      check("rst address", address, 0);
      check("rst writedata", writedata, 0);
      check("rst rsp_valid", rsp_valid, 0);
      check("rst rsp_data", rsp_data, 0);
      check("rst rsp_status", rsp_status, 0);
      check("rst cmd_ready", cmd_ready, 1);
      reset_n = 1'b1;
      @(negedge clk);

      // Single write to the output register.
      run_cmd("write", 0, 0, 32'hA5A5_0001, 32'h0, 0);

      // Single reads: address 0 returns in_port, address 1 reads as zero.
      for (int i = 0; i < 64; i++) sched[i] = 32'h1234_5678;
      run_cmd("read a0", 1, 0, 32'h0, 32'h0, 0);
      run_cmd("read a1", 1, 1, 32'h0, 32'h0, 0);

      // Poll that matches on the third attempt (bit 8 rises at cycle 5).
      for (int i = 0; i < 64; i++) sched[i] = (i >= 5) ? 32'h0000_0100 : 32'h0000_0000;
      run_cmd("poll match", 2, 0, 32'h0000_0100, 32'h0000_0100, 5);

      // Poll timeout after three attempts. The response returns the last readdata.
      for (int i = 0; i < 64; i++) sched[i] = $urandom & 32'hFFFF_FEFF;
      run_cmd("poll tmo", 2, 0, 32'h0000_0100, 32'h0000_0100, 2);

      // A zero mask matches on the first attempt.
      run_cmd("poll mask0", 2, 0, 32'hDEAD_BEEF, 32'h0, 7);

      // A zero retry count gives exactly one attempt.
      run_cmd("poll tmo0", 2, 0, 32'h0000_0100, 32'h0000_0100, 0);

      // An all-ones retry count gives 2^TW attempts.
      run_cmd("poll tmo max", 2, 0, 32'h0000_0100, 32'h0000_0100, (1 << TW) - 1);

      // Illegal op with cmd_valid held: it answers at once, and the next
      // command is accepted two cycles later.
      check("illegal ready", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_op = 2'b11; cmd_addr = 2'd2; cmd_data = 32'h5555_AAAA;
      in_port = 32'hCAFE_0003;
      @(negedge clk);
      check("illegal rsp_valid", rsp_valid, 1);
      check("illegal status", rsp_status, 2);
      check("illegal data", rsp_data, 0);
      check("illegal no cs", chipselect, 0);
      check("illegal ready low", cmd_ready, 0);
      cmd_op = 2'b01; cmd_addr = 2'd0;
      @(negedge clk);
      check("illegal rsp one cycle", rsp_valid, 0);
      check("illegal ready again", cmd_ready, 1);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("b2b read cs", chipselect, 1);
      repeat (2) @(negedge clk);
      check("b2b read rsp_valid", rsp_valid, 1);
      check("b2b read data", rsp_data, 32'hCAFE_0003);
      check("b2b read status", rsp_status, 0);
      @(negedge clk);

      // Randomized mix of commands on a 4-bit field, so that polls can match.
      for (int n = 0; n < 30; n++) begin
         for (int i = 0; i < 64; i++) sched[i] = {$urandom} & 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         d = $urandom;
         m = ($urandom_range(0, 5) == 0) ? 32'h0 : 32'h0000_000F;
         run_cmd($sformatf("rand%0d", n), $urandom_range(0, 3),
                 ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
                 d, m, $urandom_range(0, (1 << TW) - 1));
      end

      // Reset asserted during a WAIT cycle of a long poll.
      for (int i = 0; i < 64; i++) sched[i] = 32'h0;
      cmd_valid = 1'b1; cmd_op = 2'b10; cmd_addr = 2'd0;
      cmd_data = 32'h1; cmd_mask = 32'h1; cmd_timeout = '1; in_port = '0;
      @(negedge clk);
      cmd_valid = 1'b0;
      check("midrst issue cs", chipselect, 1);
      @(negedge clk);
      check("midrst wait cs", chipselect, 0);
      reset_n = 1'b0;
      #1;
      check("midrst chipselect", chipselect, 0);
      check("midrst write_n", write_n, 1);
      check("midrst cmd_ready", cmd_ready, 1);
      check("midrst address", address, 0);
      check("midrst rsp_valid", rsp_valid, 0);
      @(negedge clk);
      reset_n = 1'b1;
      nrsp = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (rsp_valid) nrsp++;
      end
      check("midrst no response", nrsp, 0);
      for (int i = 0; i < 64; i++) sched[i] = 32'h0BAD_F00D;
      run_cmd("post-rst read", 1, 0, 32'h0, 32'h0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/xb_gpio_host.md
# xb_gpio_host

Avalon-MM host that drives the crossbar GPIO register slave (2-bit word address, 32-bit data, registered readdata, zero wait states) from a simple command/response interface. It performs single writes, single reads, and masked poll-until-match reads with a bounded retry count. It sits between control logic (sequencers, RF front-end switching FSMs) and the GPIO slave, so that hardware, not only the CPU, can drive and sample crossbar GPIO.

## Interface
- ADDR_W, 2: Avalon word-address width.
- DATA_W, 32: data width.
- TMO_W, 16: poll retry-count width.

- clk  in  1  clock; all logic is on the rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE; a command is accepted on a cycle with cmd_valid & cmd_ready.
- cmd_op  in  2  00 write, 01 read, 10 poll, 11 illegal.
- cmd_addr  in  ADDR_W  target register.
- cmd_data  in  DATA_W  write data (write) or compare value (poll).
- cmd_mask  in  DATA_W  poll compare mask.
- cmd_timeout  in  TMO_W  poll retries after the first attempt.
- rsp_valid  out  1  one-cycle response strobe; there is no backpressure.
- rsp_data  out  DATA_W  read data, written data, or 0 for an illegal op.
- rsp_status  out  2  00 ok, 01 poll timeout, 10 illegal op.
- address  out  ADDR_W  Avalon address.
- chipselect  out  1  Avalon chipselect.
- write_n  out  1  Avalon write strobe, active-low.
- writedata  out  DATA_W  Avalon write data.
- readdata  in  DATA_W  Avalon read data. The slave registers it and it is valid one cycle after the address is presented.

## Operation
- States: IDLE, WRITE, ISSUE, WAIT, RESP.
- Accept: cmd_addr, cmd_data, cmd_mask, cmd_op and cmd_timeout are latched into internal registers. Inputs are ignored after acceptance. The attempt counter is cleared.
- Transitions from IDLE on accept:
  - op 00 → WRITE.
  - op 01/10 → ISSUE.
  - op 11 → RESP with status 10 and rsp_data 0. No bus cycle is issued.
- WRITE:
  - chipselect=1, write_n=0, address and writedata from the latched command, for exactly one cycle.
  - → RESP, status 00, rsp_data = latched data.
- ISSUE: chipselect=1, write_n=1, address driven; → WAIT.
- WAIT: chipselect=0. readdata is sampled this cycle.
  - read: rsp_data ← readdata, status 00 → RESP.
  - poll, (readdata & mask) == (data & mask): rsp_data ← readdata, status 00 → RESP.
  - poll, mismatch, attempt == cmd_timeout: rsp_data ← readdata, status 01 → RESP.
  - poll, mismatch otherwise: attempt += 1 → ISSUE.
- RESP: rsp_valid=1 for one cycle; → IDLE.
- Boundaries:
  - cmd_timeout=0 gives exactly one attempt.
  - All-ones cmd_timeout gives 2^TMO_W attempts. The attempt counter is TMO_W bits and never wraps, because the equality check terminates first.
  - mask=0 always matches on the first attempt.
- Bus outputs are registered. Whenever no WRITE or ISSUE cycle is in progress: chipselect=0, write_n=1. address and writedata hold their last values.
- Reset (any time, including mid-poll), applied asynchronously:
  - state → IDLE.
  - chipselect=0, write_n=1, address=0, writedata=0.
  - rsp_valid=0, rsp_data=0, rsp_status=00; cmd_ready=1.
  - No response is produced for the aborted command.

## Timing
- Accept at cycle T.
- Write: bus strobe at T+1; rsp_valid at T+2; cmd_ready at T+3.
- Read: chipselect at T+1; readdata sampled at T+2; rsp_valid at T+3.
- Poll: attempt k issues at T+1+2k and is compared at T+2+2k. A match on attempt k gives rsp_valid at T+3+2k. A timeout gives rsp_valid at T+3+2·cmd_timeout.
- Illegal op: rsp_valid at T+1.
- Back-to-back commands: the earliest next accept is the cycle after rsp_valid.
- The host never drives chipselect on two consecutive cycles.

## Test plan
- Write: op 00, addr 0, data 0xA5A5_0001 at T → write_n=0, chipselect=1, writedata 0xA5A5_0001 at T+1 only. Slave out_port = 0xA5A5_0001 from T+2. rsp_valid at T+2 with status 00.
- Read: slave in_port = 0x1234_5678, op 01 addr 0 → rsp_valid at T+3, rsp_data 0x1234_5678, status 00. Addr 1 → rsp_data 0.
- Poll match: mask 0x0000_0100, data 0x0000_0100, cmd_timeout 5. in_port bit 8 rises before the 3rd compare at T+6 → rsp_valid at T+7, status 00, exactly 3 chipselect pulses.
- Poll timeout: cmd_timeout 2 with no match → 3 chipselect pulses, rsp_valid at T+7, status 01, rsp_data = last readdata.
- Illegal op 11: rsp_valid at T+1, status 10, rsp_data 0, chipselect never asserted. cmd_valid held high → the next command is accepted at T+2.
- Reset mid-poll: assert reset_n=0 during a WAIT cycle → chipselect=0, write_n=1, cmd_ready=1 immediately. No rsp_valid afterwards; a fresh read completes normally.
